// File: rtl/feedback_out_pkg.sv
// Shared encodings and default tone constants for the feedback output stage.
package feedback_out_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEEP = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  localparam logic [7:0] HALF_L_DEF = 8'd50;
  localparam logic [7:0] HALF_R_DEF = 8'd25;

endpackage

// File: rtl/feedback_out_tone_gen.sv
// Square-wave generator: phase counter that toggles sq every `half` clocks while enabled.
module tone_gen #(
  parameter int TW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load,
  input  logic          en,
  input  logic [TW-1:0] half,
  output logic          sq
);

  logic [TW-1:0] phase;

  // load starts a burst high at phase 0; dropping en silences the output
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase <= '0;
      sq    <= 1'b0;
    end else if (load) begin
      phase <= '0;
      sq    <= 1'b1;
    end else if (en) begin
      if (phase == half - TW'(1)) begin
        phase <= '0;
        sq    <= ~sq;
      end else begin
        phase <= phase + TW'(1);
      end
    end else begin
      phase <= '0;
      sq    <= 1'b0;
    end
  end

endmodule

// File: rtl/feedback_out.sv
// Turns left/right move pulses into timed buzzer bursts plus direction LEDs.
// Optional FEEDBACK_PENDING_EN adds a one-deep slot for events arriving while busy.
//
// state | meaning
// IDLE  | silent, waiting for a move pulse
// BEEP  | tone burst for the latched direction, counting e_tick
// GAP   | silent spacer after a burst, counting e_tick
module feedback_out
  import feedback_out_pkg::*;
#(
  parameter int              TW        = 8,
  parameter logic [TW-1:0]   HALF_L    = TW'(HALF_L_DEF),
  parameter logic [TW-1:0]   HALF_R    = TW'(HALF_R_DEF),
  parameter int              CR        = 4,
  parameter logic [CR-1:0]   DUR_TICKS = CR'(8),
  parameter logic [CR-1:0]   GAP_TICKS = CR'(2)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic e_tick,
  input  logic left_i,
  input  logic right_i,
  output logic tone_o,
  output logic led_left_o,
  output logic led_right_o,
  output logic busy_o
);

  localparam logic [CR-1:0] DUR_EFF  = (DUR_TICKS == '0) ? CR'(1) : DUR_TICKS;
  localparam logic          GAP_NONE = (GAP_TICKS == '0);

  state_t        state, state_nxt;
  logic          dir, dir_nxt;
  logic [CR-1:0] cnt, cnt_nxt, cnt_inc;
  logic          load, done, tone_en;
  logic          led_left_nxt, led_right_nxt, busy_nxt;
  logic          ev, ev_dir;
  logic [TW-1:0] half;

`ifdef FEEDBACK_PENDING_EN
  logic pend_valid, pend_valid_nxt;
  logic pend_dir, pend_dir_nxt;
`endif

  assign ev      = left_i | right_i;
  assign ev_dir  = left_i ? DIR_L : DIR_R;
  assign cnt_inc = cnt + CR'(1);
  assign half    = (dir == DIR_R) ? HALF_R : HALF_L;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      dir         <= DIR_L;
      cnt         <= '0;
      led_left_o  <= 1'b0;
      led_right_o <= 1'b0;
      busy_o      <= 1'b0;
`ifdef FEEDBACK_PENDING_EN
      pend_valid  <= 1'b0;
      pend_dir    <= DIR_L;
`endif
    end else begin
      state       <= state_nxt;
      dir         <= dir_nxt;
      cnt         <= cnt_nxt;
      led_left_o  <= led_left_nxt;
      led_right_o <= led_right_nxt;
      busy_o      <= busy_nxt;
`ifdef FEEDBACK_PENDING_EN
      pend_valid  <= pend_valid_nxt;
      pend_dir    <= pend_dir_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    cnt_nxt   = cnt;
    load      = 1'b0;
    done      = 1'b0;
`ifdef FEEDBACK_PENDING_EN
    pend_valid_nxt = pend_valid;
    pend_dir_nxt   = pend_dir;
`endif
    case (state)
      IDLE: begin
`ifdef FEEDBACK_PENDING_EN
        if (pend_valid) begin
          state_nxt      = BEEP;
          dir_nxt        = pend_dir;
          load           = 1'b1;
          cnt_nxt        = '0;
          pend_valid_nxt = 1'b0;
        end else if (ev) begin
          state_nxt = BEEP;
          dir_nxt   = ev_dir;
          load      = 1'b1;
          cnt_nxt   = '0;
          // simultaneous pair: left plays now, right waits in the slot
          if (left_i && right_i) begin
            pend_valid_nxt = 1'b1;
            pend_dir_nxt   = DIR_R;
          end
        end
`else
        if (ev) begin
          state_nxt = BEEP;
          dir_nxt   = ev_dir;
          load      = 1'b1;
          cnt_nxt   = '0;
        end
`endif
      end
      BEEP: begin
        if (e_tick) begin
          if (cnt_inc == DUR_EFF) begin
            cnt_nxt = '0;
            if (GAP_NONE) done = 1'b1;
            else state_nxt = GAP;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      GAP: begin
        if (e_tick) begin
          if (cnt_inc == GAP_TICKS) begin
            cnt_nxt = '0;
            done    = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (done) begin
`ifdef FEEDBACK_PENDING_EN
      // chain straight into the queued burst so busy never drops
      if (pend_valid) begin
        state_nxt      = BEEP;
        dir_nxt        = pend_dir;
        load           = 1'b1;
        pend_valid_nxt = 1'b0;
      end else if (ev) begin
        state_nxt = BEEP;
        dir_nxt   = ev_dir;
        load      = 1'b1;
      end else begin
        state_nxt = IDLE;
      end
`else
      state_nxt = IDLE;
`endif
    end

`ifdef FEEDBACK_PENDING_EN
    if (state != IDLE && !done && !pend_valid && ev) begin
      pend_valid_nxt = 1'b1;
      pend_dir_nxt   = ev_dir;
    end
`endif
  end

  always_comb begin
    tone_en       = (state == BEEP) && (state_nxt == BEEP) && !load;
    busy_nxt      = (state_nxt != IDLE);
    led_left_nxt  = (state_nxt == BEEP) && (dir_nxt == DIR_L);
    led_right_nxt = (state_nxt == BEEP) && (dir_nxt == DIR_R);
  end

  tone_gen #(
    .TW(TW)
  ) u_tone_gen (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .load  (load),
    .en    (tone_en),
    .half  (half),
    .sq    (tone_o)
  );

endmodule

// File: tb/tb_feedback_out.sv
// Scoreboard bench for feedback_out: expected bursts queued at stimulus, checked by a negedge monitor.
module tb_feedback_out;

  typedef struct {
    bit dir;
    int half;
    int dur;
    int gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic e_tick, left, right;
  logic tone, led_l, led_r, busy;
  logic e_tick2, left2, right2;
  logic tone2, led_l2, led_r2, busy2;

  int n_checks = 0;
  int n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  feedback_out dut (
    .clk_i(clk), .rst_ni(rst_n), .e_tick(e_tick), .left_i(left), .right_i(right),
    .tone_o(tone), .led_left_o(led_l), .led_right_o(led_r), .busy_o(busy)
  );

  feedback_out #(
    .HALF_L(8'd1), .DUR_TICKS(4'd0), .GAP_TICKS(4'd0)
  ) dut_short (
    .clk_i(clk), .rst_ni(rst_n), .e_tick(e_tick2), .left_i(left2), .right_i(right2),
    .tone_o(tone2), .led_left_o(led_l2), .led_right_o(led_r2), .busy_o(busy2)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // e_tick every 100 clocks, changed just after the edge
  int tick_div = 0;
  initial begin
    e_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_div++;
      e_tick = (tick_div % 100 == 0);
    end
  end

  // monitor state
  bit   in_burst = 0, in_gap = 0, prev_busy = 0, prev_tone = 0;
  int   run = 0, half_bad = 0, tick_cnt = 0, gap_cnt = 0, silent_bad = 0, busy_falls = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_burst  = 0;
      in_gap    = 0;
      prev_busy = 0;
    end else begin
      if ((led_l || led_r) && !in_burst) begin
        if (in_gap) begin
          check("gap_ticks", gap_cnt, cur.gap);
          in_gap = 0;
        end
        if (sb.size() == 0) begin
          check("unexpected_burst", 1, 0);
          cur = '{dir: 0, half: 0, dur: 0, gap: 0};
        end else begin
          cur = sb.pop_front();
        end
        check("burst_dir", int'(led_r), int'(cur.dir));
        check("tone_start", int'(tone), 1);
        in_burst  = 1;
        tick_cnt  = 0;
        run       = 0;
        half_bad  = 0;
        prev_tone = tone;
      end
      if (in_burst && (led_l || led_r)) begin
        if (tone != prev_tone) begin
          if (run != cur.half) half_bad++;
          run = 0;
        end
        run++;
        prev_tone = tone;
        if (e_tick) tick_cnt++;
        if ((led_l && led_r) || (led_r != cur.dir)) half_bad++;
      end else if (in_burst) begin
        check("burst_ticks", tick_cnt, cur.dur);
        check("tone_period", half_bad, 0);
        in_burst = 0;
        in_gap   = 1;
        gap_cnt  = 0;
      end
      if (in_gap) begin
        if (busy) begin
          if (e_tick) gap_cnt++;
        end else begin
          check("gap_ticks", gap_cnt, cur.gap);
          in_gap = 0;
        end
      end
      if (!led_l && !led_r && tone) silent_bad++;
      if (prev_busy && !busy) busy_falls++;
      prev_busy = busy;
    end
  end

  task automatic pulse(input bit l, input bit r);
    @(posedge clk); #1;
    left  = l;
    right = r;
    @(posedge clk); #1;
    left  = 1'b0;
    right = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!(sb.size() == 0 && !in_burst && !in_gap && !busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) check("drain_timeout", 1, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int falls0;
  int n_wait;

  initial begin
    rst_n = 1'b0;
    left = 1'b0; right = 1'b0;
    e_tick2 = 1'b0; left2 = 1'b0; right2 = 1'b0;
    wait_clks(4);
    check("rst_tone", int'(tone), 0);
    check("rst_led_l", int'(led_l), 0);
    check("rst_led_r", int'(led_r), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_busy2", int'(busy2), 0);
    rst_n = 1'b1;
    wait_clks(3);

    // single left burst
    falls0 = busy_falls;
    sb.push_back('{dir: 0, half: 50, dur: 8, gap: 2});
    pulse(1'b1, 1'b0);
    wait_done(2500);
    check("left_busy_falls", busy_falls - falls0, 1);

    // single right burst
    falls0 = busy_falls;
    sb.push_back('{dir: 1, half: 25, dur: 8, gap: 2});
    pulse(1'b0, 1'b1);
    wait_done(2500);
    check("right_busy_falls", busy_falls - falls0, 1);

    // simultaneous left and right
    falls0 = busy_falls;
    sb.push_back('{dir: 0, half: 50, dur: 8, gap: 2});
`ifdef FEEDBACK_PENDING_EN
    sb.push_back('{dir: 1, half: 25, dur: 8, gap: 2});
`endif
    pulse(1'b1, 1'b1);
    wait_done(5000);
    check("pair_busy_falls", busy_falls - falls0, 1);

    // right pulses during the gap of a left burst
    falls0 = busy_falls;
    sb.push_back('{dir: 0, half: 50, dur: 8, gap: 2});
    pulse(1'b1, 1'b0);
    n_wait = 0;
    while (!(busy && !led_l) && n_wait < 2500) begin
      @(posedge clk); #1;
      n_wait++;
    end
    if (n_wait >= 2500) check("gap_wait_timeout", 1, 0);
`ifdef FEEDBACK_PENDING_EN
    sb.push_back('{dir: 1, half: 25, dur: 8, gap: 2});
`endif
    wait_clks(10);
    pulse(1'b0, 1'b1);
    wait_clks(10);
    pulse(1'b0, 1'b1);
    wait_clks(10);
    pulse(1'b0, 1'b1);
    wait_done(5000);
    check("gapev_busy_falls", busy_falls - falls0, 1);

    // reset asserted mid-burst
    sb.push_back('{dir: 0, half: 50, dur: 8, gap: 2});
    pulse(1'b1, 1'b0);
    wait_clks(150);
    check("mid_busy", int'(busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tone", int'(tone), 0);
    check("mid_rst_led_l", int'(led_l), 0);
    check("mid_rst_busy", int'(busy), 0);
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(5);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_led_l", int'(led_l), 0);
    check("post_rst_sb", sb.size(), 0);
    sb.push_back('{dir: 1, half: 25, dur: 8, gap: 2});
    pulse(1'b0, 1'b1);
    wait_done(2500);

    // zero duration / zero gap / half-period 1
    @(posedge clk); #1;
    left2 = 1'b1;
    @(posedge clk); #1;
    left2 = 1'b0;
    check("short_tone_start", int'(tone2), 1);
    check("short_led_l", int'(led_l2), 1);
    check("short_led_r", int'(led_r2), 0);
    check("short_busy", int'(busy2), 1);
    @(posedge clk); #1;
    check("short_toggle1", int'(tone2), 0);
    @(posedge clk); #1;
    check("short_toggle2", int'(tone2), 1);
    e_tick2 = 1'b1;
    @(posedge clk); #1;
    e_tick2 = 1'b0;
    check("short_end_busy", int'(busy2), 0);
    check("short_end_led", int'(led_l2), 0);
    check("short_end_tone", int'(tone2), 0);

    check("silent_tone", silent_bad, 0);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
